// File: rtl/uart_dbg_bridge.sv
`timescale 1ns/1ps
// UART-to-MMIO debug bridge: serial command frames drive MMIO reads/writes, status and read data return over TX.
// Define UART_DBG_CHKSUM_EN for the trailing XOR checksum on command frames and read responses.

module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF     = CW'(CPB / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d;
    logic          rx_s;

    assign rx_s         = sync_q[1];
    assign o_data       = data_q;
    assign o_data_valid = valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Start bit is re-checked at its midpoint; every later sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_data,
    output logic       o_tx_out,
    output logic       o_tx_busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);

    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;

    assign o_tx_out  = shift_q[0];
    assign o_tx_busy = (state_q == TX_BUSY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Shift register is refilled with ones so the line rests high after the stop bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            TX_IDLE: begin
                if (i_tx_start) begin
                    shift_d = {1'b1, i_data, 1'b0};
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b1, shift_q[9:1]};
                    if (bit_q == 4'd9) state_d = TX_IDLE;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end
endmodule

module uart_dbg_bridge #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int ADDR_W    = 16,
    parameter int FRAME_TO  = 1_000_000,
    parameter int BUS_TO    = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_in,
    output logic              o_tx_out,
    output logic              o_bus_sel,
    output logic              o_bus_we,
    output logic              o_bus_re,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [15:0]       o_bus_wdata,
    input  logic [15:0]       i_bus_rdata,
    input  logic              i_bus_rdy,
    output logic              o_busy,
    output logic              o_err
);
    localparam int FTW = $clog2(FRAME_TO + 1);
    localparam int BTW = $clog2(BUS_TO + 1);
    localparam logic [FTW-1:0] FRAME_LAST = FTW'(FRAME_TO - 1);
    localparam logic [BTW-1:0] BUS_LAST   = BTW'(BUS_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L, ST_CHK, ST_BUS, ST_SEND
    } state_t;

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [15:0]       addr_q, addr_d, data_q, data_d;
    logic [FTW-1:0]    ftmr_q, ftmr_d;
    logic [BTW-1:0]    btmr_q, btmr_d;
    logic [23:0]       resp_q, resp_d;
    logic [1:0]        rcnt_q, rcnt_d, tx_ph_q, tx_ph_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              sel_q, sel_d, we_q, we_d, re_q, re_d, err_q, err_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [15:0]       bwdata_q, bwdata_d;
    logic              enter_bus;
    logic [7:0]        rx_data;
    logic              rx_valid, tx_busy;
`ifdef UART_DBG_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .i_clk(i_clk), .i_rst(~i_rst_n), .i_rx(i_rx_in),
        .o_data(rx_data), .o_data_valid(rx_valid)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .i_clk(i_clk), .i_rst(~i_rst_n), .i_tx_start(tx_start_q), .i_data(tx_data_q),
        .o_tx_out(o_tx_out), .o_tx_busy(tx_busy)
    );

    assign o_bus_sel   = sel_q;
    assign o_bus_we    = we_q;
    assign o_bus_re    = re_q;
    assign o_bus_addr  = baddr_q;
    assign o_bus_wdata = bwdata_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ftmr_q     <= '0;
            btmr_q     <= '0;
            resp_q     <= '0;
            rcnt_q     <= '0;
            tx_ph_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            baddr_q    <= '0;
            bwdata_q   <= '0;
`ifdef UART_DBG_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ftmr_q     <= ftmr_d;
            btmr_q     <= btmr_d;
            resp_q     <= resp_d;
            rcnt_q     <= rcnt_d;
            tx_ph_q    <= tx_ph_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            re_q       <= re_d;
            err_q      <= err_d;
            baddr_q    <= baddr_d;
            bwdata_q   <= bwdata_d;
`ifdef UART_DBG_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ftmr_d     = '0;
        btmr_d     = btmr_q;
        resp_d     = resp_q;
        rcnt_d     = rcnt_q;
        tx_ph_d    = tx_ph_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        sel_d      = sel_q;
        we_d       = we_q;
        re_d       = re_q;
        err_d      = 1'b0;
        baddr_d    = baddr_q;
        bwdata_d   = bwdata_q;
        enter_bus  = 1'b0;
`ifdef UART_DBG_CHKSUM_EN
        chk_d      = chk_q;
        if (rx_valid) chk_d = chk_q ^ rx_data;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
`ifdef UART_DBG_CHKSUM_EN
                    chk_d = rx_data;
`endif
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        is_wr_d = (rx_data == 8'h57);
                        state_d = ST_ADDR_H;
                    end else begin
                        resp_d  = {8'h3F, 16'h0000};
                        rcnt_d  = 2'd1;
                        err_d   = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_ADDR_H: if (rx_valid) begin
                addr_d[15:8] = rx_data;
                state_d      = ST_ADDR_L;
            end
            ST_ADDR_L: if (rx_valid) begin
                addr_d[7:0] = rx_data;
`ifdef UART_DBG_CHKSUM_EN
                state_d = is_wr_q ? ST_DATA_H : ST_CHK;
`else
                if (is_wr_q) state_d = ST_DATA_H;
                else         enter_bus = 1'b1;
`endif
            end
            ST_DATA_H: if (rx_valid) begin
                data_d[15:8] = rx_data;
                state_d      = ST_DATA_L;
            end
            ST_DATA_L: if (rx_valid) begin
                data_d[7:0] = rx_data;
`ifdef UART_DBG_CHKSUM_EN
                state_d = ST_CHK;
`else
                enter_bus = 1'b1;
`endif
            end
`ifdef UART_DBG_CHKSUM_EN
            ST_CHK: if (rx_valid) begin
                if (rx_data == chk_q) begin
                    enter_bus = 1'b1;
                end else begin
                    resp_d  = {8'h21, 16'h0000};
                    rcnt_d  = 2'd1;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
`endif
            ST_BUS: begin
                if (i_bus_rdy) begin
                    sel_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    btmr_d  = '0;
                    state_d = ST_SEND;
                    if (is_wr_q) begin
                        resp_d = {8'h4B, 16'h0000};
                        rcnt_d = 2'd1;
                    end else begin
`ifdef UART_DBG_CHKSUM_EN
                        resp_d = {i_bus_rdata, i_bus_rdata[15:8] ^ i_bus_rdata[7:0]};
                        rcnt_d = 2'd3;
`else
                        resp_d = {i_bus_rdata, 8'h00};
                        rcnt_d = 2'd2;
`endif
                    end
                end else if (btmr_q == BUS_LAST) begin
                    sel_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    btmr_d  = '0;
                    resp_d  = {8'h45, 16'h0000};
                    rcnt_d  = 2'd1;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    btmr_d = btmr_q + 1'b1;
                end
            end
            // tx_ph: 0 = free to start, 1 = waiting for busy to rise, 2 = waiting for busy to fall.
            ST_SEND: begin
                case (tx_ph_q)
                    2'd0: if (!tx_busy) begin
                        if (rcnt_q != 2'd0) begin
                            tx_start_d = 1'b1;
                            tx_data_d  = resp_q[23:16];
                            resp_d     = {resp_q[15:0], 8'h00};
                            rcnt_d     = rcnt_q - 1'b1;
                            tx_ph_d    = 2'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    2'd1: if (tx_busy) tx_ph_d = 2'd2;
                    default: if (!tx_busy) tx_ph_d = 2'd0;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte silence inside a frame abandons it without a response.
        if (state_q inside {ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L, ST_CHK} && !rx_valid) begin
            if (ftmr_q == FRAME_LAST) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                ftmr_d = ftmr_q + 1'b1;
            end
        end

        if (enter_bus) begin
            sel_d    = 1'b1;
            we_d     = is_wr_q;
            re_d     = ~is_wr_q;
            baddr_d  = addr_d[ADDR_W-1:0];
            bwdata_d = data_d;
            btmr_d   = '0;
            state_d  = ST_BUS;
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
`timescale 1ns/1ps
// Directed bench for uart_dbg_bridge: serial frames in, bus target model, serial responses decoded and scored.

module tb_uart_dbg_bridge;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 16;
  localparam int FRAME_TO = 500;
  localparam int BUS_TO   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;
  logic tx_out, bus_sel, bus_we, bus_re, bus_rdy, busy, err;
  logic [ADDR_W-1:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] tgt_rdata = 16'h0000;
  int tgt_wait = 0;
  logic tgt_dead = 1'b0;
  int sel_run = 0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] frm_q[$];

  // bus / error monitor state
  int txn_count = 0, txn_cycles = 0, err_cycles = 0, err_pulses = 0;
  logic [15:0] txn_addr = 16'h0, txn_wdata = 16'h0;
  logic txn_we = 1'b0, txn_re = 1'b0, txn_stable = 1'b1;
  logic prev_sel = 1'b0, prev_err = 1'b0;

  uart_dbg_bridge #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .ADDR_W(ADDR_W),
    .FRAME_TO(FRAME_TO), .BUS_TO(BUS_TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_in(rx_in), .o_tx_out(tx_out),
    .o_bus_sel(bus_sel), .o_bus_we(bus_we), .o_bus_re(bus_re),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_rdata(tgt_rdata), .i_bus_rdy(bus_rdy),
    .o_busy(busy), .o_err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- bus target model ----------------
  always @(posedge clk) sel_run <= bus_sel ? sel_run + 1 : 0;
  assign bus_rdy = bus_sel && !tgt_dead && (sel_run >= tgt_wait);

  always @(negedge clk) begin
    if (bus_sel) begin
      if (!prev_sel) begin
        txn_count++;
        txn_cycles = 1;
        txn_addr = bus_addr;
        txn_wdata = bus_wdata;
        txn_we = bus_we;
        txn_re = bus_re;
        txn_stable = 1'b1;
      end else begin
        txn_cycles++;
        if (bus_addr !== txn_addr || bus_we !== txn_we || bus_re !== txn_re || bus_wdata !== txn_wdata)
          txn_stable = 1'b0;
      end
    end
    if (err) err_cycles++;
    if (err && !prev_err) err_pulses++;
    prev_sel = bus_sel;
    prev_err = err;
  end

  // ---------------- serial TX decoder ----------------
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_out);
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = tx_out;
      end
      repeat (CPB) @(posedge clk);
      got_q.push_back(b);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frm();
`ifdef UART_DBG_CHKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frm_q[i]) begin
      send_byte(frm_q[i]);
      x = x ^ frm_q[i];
    end
    send_byte(x);
`else
    foreach (frm_q[i]) send_byte(frm_q[i]);
`endif
    frm_q.delete();
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (got_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_sel, bus_we, bus_re, busy, err, tx_out} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000001", {bus_sel, bus_we, bus_re, busy, err, tx_out});
    end
    checks++;
    if (bus_addr !== 16'h0000 || bus_wdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_bus got addr=%h wdata=%h exp 0000/0000", bus_addr, bus_wdata);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus_sel, busy, err, tx_out} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0001", {bus_sel, busy, err, tx_out});
    end
  endtask

  task automatic test_write();
    int t0, e0;
    bit ok;
    logic [7:0] g, e;
    tgt_wait = 0; tgt_dead = 1'b0;
    t0 = txn_count; e0 = err_pulses;
    frm_q = '{8'h57, 8'h00, 8'h04, 8'h12, 8'h34};
    exp_q.push_back(8'h4B);
    send_frm();
    wait_done(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_timeout got=busy/%0d bytes exp=idle/1", got_q.size()); end
    checks++;
    if (txn_count - t0 != 1 || txn_cycles != 1) begin
      failures++; $display("FAIL wr_cycle got txns=%0d cycles=%0d exp 1/1", txn_count - t0, txn_cycles);
    end
    checks++;
    if ({txn_we, txn_re} !== 2'b10) begin failures++; $display("FAIL wr_strobe got=%b exp=10", {txn_we, txn_re}); end
    checks++;
    if (txn_addr !== 16'h0004 || txn_wdata !== 16'h1234) begin
      failures++; $display("FAIL wr_addr_data got=%h/%h exp=0004/1234", txn_addr, txn_wdata);
    end
    checks++;
    if (err_pulses != e0) begin failures++; $display("FAIL wr_err got=%0d exp=0", err_pulses - e0); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL wr_nbytes got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL wr_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_read();
    int t0, e0;
    bit ok;
    logic [7:0] g, e;
    tgt_wait = 3; tgt_dead = 1'b0; tgt_rdata = 16'hA55A;
    t0 = txn_count; e0 = err_pulses;
    frm_q = '{8'h52, 8'h00, 8'h05};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`ifdef UART_DBG_CHKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    send_frm();
    wait_done(exp_q.size(), ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_timeout got=busy/%0d bytes exp=idle/%0d", got_q.size(), exp_q.size()); end
    checks++;
    if (txn_count - t0 != 1 || txn_cycles != 4) begin
      failures++; $display("FAIL rd_cycle got txns=%0d cycles=%0d exp 1/4", txn_count - t0, txn_cycles);
    end
    checks++;
    if ({txn_we, txn_re, txn_stable} !== 3'b011) begin
      failures++; $display("FAIL rd_strobe got we/re/stable=%b exp=011", {txn_we, txn_re, txn_stable});
    end
    checks++;
    if (txn_addr !== 16'h0005) begin failures++; $display("FAIL rd_addr got=%h exp=0005", txn_addr); end
    checks++;
    if (err_pulses != e0) begin failures++; $display("FAIL rd_err got=%0d exp=0", err_pulses - e0); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rd_nbytes got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL rd_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
    tgt_wait = 0;
  endtask

  task automatic test_bad_opcode();
    int t0, e0, c0;
    bit ok;
    logic [7:0] g, e;
    t0 = txn_count; e0 = err_pulses; c0 = err_cycles;
    exp_q.push_back(8'h3F);
    send_byte(8'h10);
    wait_done(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bad_timeout got=busy/%0d bytes exp=idle/1", got_q.size()); end
    checks++;
    if (err_pulses - e0 != 1 || err_cycles - c0 != 1) begin
      failures++; $display("FAIL bad_err got pulses=%0d cycles=%0d exp 1/1", err_pulses - e0, err_cycles - c0);
    end
    checks++;
    if (txn_count != t0) begin failures++; $display("FAIL bad_bus got=%0d exp=0", txn_count - t0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL bad_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
`ifdef UART_DBG_CHKSUM_EN
    t0 = txn_count;
    exp_q.push_back(8'h21);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    wait_done(1, ok);
    checks++;
    if (txn_count != t0) begin failures++; $display("FAIL chk_bus got=%0d exp=0", txn_count - t0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL chk_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
`endif
    // a following valid read completes normally
    t0 = txn_count;
    tgt_rdata = 16'h1234;
    frm_q = '{8'h52, 8'h00, 8'h06};
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
`ifdef UART_DBG_CHKSUM_EN
    exp_q.push_back(8'h26);
`endif
    send_frm();
    wait_done(exp_q.size(), ok);
    checks++;
    if (txn_count - t0 != 1 || txn_addr !== 16'h0006) begin
      failures++; $display("FAIL bad_next_bus got txns=%0d addr=%h exp 1/0006", txn_count - t0, txn_addr);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL bad_next_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_bus_timeout();
    int t0, e0;
    bit ok;
    logic [7:0] g, e;
    tgt_dead = 1'b1;
    t0 = txn_count; e0 = err_pulses;
    frm_q = '{8'h52, 8'h00, 8'h07};
    exp_q.push_back(8'h45);
    send_frm();
    wait_done(1, ok);
    checks++;
    if (txn_count - t0 != 1 || txn_cycles != BUS_TO) begin
      failures++; $display("FAIL bto_cycles got txns=%0d cycles=%0d exp 1/%0d", txn_count - t0, txn_cycles, BUS_TO);
    end
    checks++;
    if ({txn_re, txn_stable} !== 2'b11) begin failures++; $display("FAIL bto_strobe got=%b exp=11", {txn_re, txn_stable}); end
    checks++;
    if (err_pulses - e0 != 1) begin failures++; $display("FAIL bto_err got=%0d exp=1", err_pulses - e0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL bto_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
    tgt_dead = 1'b0;
  endtask

  task automatic test_frame_timeout();
    int t0, e0, c0;
    bit ok;
    logic [7:0] g, e;
    t0 = txn_count; e0 = err_pulses; c0 = err_cycles;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (FRAME_TO - 50) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fto_early got busy=%b exp=1", busy); end
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL fto_idle got busy=1 exp=0"); end
    repeat (150) @(negedge clk);
    checks++;
    if (err_pulses - e0 != 1 || err_cycles - c0 != 1) begin
      failures++; $display("FAIL fto_err got pulses=%0d cycles=%0d exp 1/1", err_pulses - e0, err_cycles - c0);
    end
    checks++;
    if (txn_count != t0 || got_q.size() != 0) begin
      failures++; $display("FAIL fto_quiet got txns=%0d bytes=%0d exp 0/0", txn_count - t0, got_q.size());
    end
    got_q.delete();
    frm_q = '{8'h57, 8'h00, 8'h08, 8'hAB, 8'hCD};
    exp_q.push_back(8'h4B);
    send_frm();
    wait_done(1, ok);
    checks++;
    if (txn_addr !== 16'h0008 || txn_wdata !== 16'hABCD || txn_we !== 1'b1) begin
      failures++; $display("FAIL fto_next_bus got=%h/%h we=%b exp=0008/abcd we=1", txn_addr, txn_wdata, txn_we);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL fto_next_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] g, e;
    // reset while the bus cycle is in progress
    tgt_dead = 1'b1;
    frm_q = '{8'h52, 8'h00, 8'h09};
    send_frm();
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus_sel) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rstbus_enter got sel=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_sel, bus_we, bus_re, busy, err, tx_out} !== 6'b000001 || bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin
      failures++;
      $display("FAIL rstbus_async got ctl=%b addr=%h wdata=%h exp 000001/0000/0000",
               {bus_sel, bus_we, bus_re, busy, err, tx_out}, bus_addr, bus_wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tgt_dead = 1'b0;
    repeat (150) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstbus_quiet got bytes=%0d busy=%b exp 0/0", got_q.size(), busy);
    end
    got_q.delete();
    frm_q = '{8'h57, 8'h00, 8'h0A, 8'h55, 8'hAA};
    exp_q.push_back(8'h4B);
    send_frm();
    wait_done(1, ok);
    checks++;
    if (txn_addr !== 16'h000A || txn_wdata !== 16'h55AA) begin
      failures++; $display("FAIL rstbus_next got=%h/%h exp=000a/55aa", txn_addr, txn_wdata);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL rstbus_next_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();

    // reset while the response is on the wire
    tgt_rdata = 16'h00FF;
    frm_q = '{8'h52, 8'h00, 8'h0B};
    send_frm();
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!tx_out) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rsttx_start got tx_out=1 exp=0"); end
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy, bus_sel} !== 3'b100) begin
      failures++; $display("FAIL rsttx_async got tx/busy/sel=%b exp=100", {tx_out, busy, bus_sel});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    got_q.delete();
    frm_q = '{8'h57, 8'h00, 8'h0C, 8'h01, 8'h02};
    exp_q.push_back(8'h4B);
    send_frm();
    wait_done(1, ok);
    checks++;
    if (txn_addr !== 16'h000C || txn_wdata !== 16'h0102 || got_q.size() != 1) begin
      failures++; $display("FAIL rsttx_next got=%h/%h bytes=%0d exp=000c/0102 bytes=1", txn_addr, txn_wdata, got_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL rsttx_next_tx got=%h exp=%h", g, e); end
    end
    got_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_bus_timeout();
    test_frame_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
